// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM state types for the cache-to-AXI arbiter.
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam int         ID_ICACHE  = 0;
  localparam int         ID_DCACHE  = 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with one-hot grant; a tie goes to the port not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last_grant;  // index of the port granted most recently

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) o_gnt = r_last_grant ? 2'b01 : 2'b10;
      else                o_gnt = i_req;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             r_last_grant <= 1'b0;
    else if (o_gnt != 2'b00) r_last_grant <= o_gnt[1];
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Merges icache and dcache burst ports onto one AXI3 master: round-robin reads tagged by ID,
// dcache write pass-through, and icache fetches held off while their line is being written back.
module cache_axi_arbiter
  import axi_pkg::*;
#(
  parameter int LINE_OFFSET = 5,
  parameter int ID_W        = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     i_araddr,
  input  logic [3:0]      i_arlen,
  input  logic [2:0]      i_arsize,
  input  logic            i_arvalid,
  output logic            i_arready,
  output logic [31:0]     i_rdata,
  output logic            i_rlast,
  output logic            i_rvalid,
  input  logic            i_rready,
  input  logic [31:0]     d_araddr,
  input  logic [3:0]      d_arlen,
  input  logic [2:0]      d_arsize,
  input  logic            d_arvalid,
  output logic            d_arready,
  output logic [31:0]     d_rdata,
  output logic            d_rlast,
  output logic            d_rvalid,
  input  logic            d_rready,
  input  logic [31:0]     d_awaddr,
  input  logic [3:0]      d_awlen,
  input  logic [2:0]      d_awsize,
  input  logic            d_awvalid,
  output logic            d_awready,
  input  logic [31:0]     d_wdata,
  input  logic [3:0]      d_wstrb,
  input  logic            d_wlast,
  input  logic            d_wvalid,
  output logic            d_wready,
  output logic            d_bvalid,
  input  logic            d_bready,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
  output logic            err_id
);

  r_state_t        r_rd_state, w_rd_state_next;
  w_state_t        r_wr_state, w_wr_state_next;
  logic [31:0]     r_araddr, r_awaddr;
  logic [3:0]      r_arlen, r_awlen;
  logic [2:0]      r_arsize, r_awsize;
  logic [ID_W-1:0] r_arid, r_awid;
  logic            r_rd_owner;  // 1 = dcache owns the read channel
  logic            r_i_arready, r_d_arready, r_d_awready, r_err_id;
  logic [1:0]      w_rd_gnt;
  logic            w_i_hazard, w_rid_ok, w_aw_take;
  logic            w_unused;

  assign w_unused = ^{rresp, bresp, bid};

  // Blocked only while a write-back to the same line is in flight.
  assign w_i_hazard = (r_wr_state != W_IDLE) &&
                      (i_araddr[31:LINE_OFFSET] == r_awaddr[31:LINE_OFFSET]);

  rr_arb2 u_rd_arb (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (r_rd_state == R_IDLE),
    .i_req  ({d_arvalid, i_arvalid & ~w_i_hazard}),
    .o_gnt  (w_rd_gnt)
  );

  assign w_rid_ok  = (rid == r_arid);
  assign w_aw_take = (r_wr_state == W_IDLE) && d_awvalid;

  assign i_arready = r_i_arready;
  assign d_arready = r_d_arready;
  assign d_awready = r_d_awready;
  assign err_id    = r_err_id;
  assign arid      = r_arid;
  assign araddr    = r_araddr;
  assign arlen     = r_arlen;
  assign arsize    = r_arsize;
  assign arburst   = BURST_INCR;
  assign awid      = r_awid;
  assign awaddr    = r_awaddr;
  assign awlen     = r_awlen;
  assign awsize    = r_awsize;
  assign awburst   = BURST_INCR;
  assign wid       = r_awid;
  assign wdata     = d_wdata;
  assign wstrb     = d_wstrb;
  assign wlast     = d_wlast;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_state <= R_IDLE;
      r_wr_state <= W_IDLE;
    end else begin
      r_rd_state <= w_rd_state_next;
      r_wr_state <= w_wr_state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arsize    <= '0;
      r_arid      <= '0;
      r_rd_owner  <= 1'b0;
      r_i_arready <= 1'b0;
      r_d_arready <= 1'b0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_awsize    <= '0;
      r_awid      <= '0;
      r_d_awready <= 1'b0;
      r_err_id    <= 1'b0;
    end else begin
      r_i_arready <= w_rd_gnt[0];
      r_d_arready <= w_rd_gnt[1];
      if (w_rd_gnt[1]) begin
        r_araddr   <= d_araddr;
        r_arlen    <= d_arlen;
        r_arsize   <= d_arsize;
        r_arid     <= ID_W'(ID_DCACHE);
        r_rd_owner <= 1'b1;
      end else if (w_rd_gnt[0]) begin
        r_araddr   <= i_araddr;
        r_arlen    <= i_arlen;
        r_arsize   <= i_arsize;
        r_arid     <= ID_W'(ID_ICACHE);
        r_rd_owner <= 1'b0;
      end
      r_d_awready <= w_aw_take;
      if (w_aw_take) begin
        r_awaddr <= d_awaddr;
        r_awlen  <= d_awlen;
        r_awsize <= d_awsize;
        r_awid   <= ID_W'(ID_DCACHE);
      end
      if ((r_rd_state == R_DATA) && rvalid && !w_rid_ok) r_err_id <= 1'b1;
    end
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    arvalid  = 1'b0;
    rready   = 1'b0;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    i_rlast  = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    d_rlast  = 1'b0;
    case (r_rd_state)
      R_IDLE: if (w_rd_gnt != 2'b00) w_rd_state_next = R_ADDR;
      R_ADDR: begin
        arvalid = 1'b1;
        if (arready) w_rd_state_next = R_DATA;
      end
      R_DATA: begin
        // Beats carrying a foreign ID are neither forwarded nor accepted.
        if (w_rid_ok) begin
          if (r_rd_owner) begin
            d_rvalid = rvalid;
            d_rdata  = rdata;
            d_rlast  = rlast;
            rready   = d_rready;
            if (rvalid && d_rready && rlast) w_rd_state_next = R_IDLE;
          end else begin
            i_rvalid = rvalid;
            i_rdata  = rdata;
            i_rlast  = rlast;
            rready   = i_rready;
            if (rvalid && i_rready && rlast) w_rd_state_next = R_IDLE;
          end
        end
      end
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_wr_state_next = r_wr_state;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    d_wready = 1'b0;
    d_bvalid = 1'b0;
    bready   = 1'b0;
    case (r_wr_state)
      W_IDLE: if (d_awvalid) w_wr_state_next = W_ADDR;
      W_ADDR: begin
        awvalid = 1'b1;
        if (awready) w_wr_state_next = W_DATA;
      end
      W_DATA: begin
        wvalid   = d_wvalid;
        d_wready = wready;
        if (d_wvalid && wready && d_wlast) w_wr_state_next = W_RESP;
      end
      W_RESP: begin
        d_bvalid = bvalid;
        bready   = d_bready;
        if (bvalid && d_bready) w_wr_state_next = W_IDLE;
      end
      default: w_wr_state_next = W_IDLE;
    endcase
  end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Merges the instruction-cache burst read port and the data-cache burst read/write ports into the single AXI3 master port of the CPU core. It sits directly downstream of the data cache's burst AXI interface and of the instruction cache. Reads are arbitrated round-robin and tagged by ID. The single write path is passed through. An instruction fetch is blocked while it targets a cache line with an outstanding dcache write-back.

## Interface
- `LINE_OFFSET`, default 5: byte-offset width of a cache line; used for the write-hazard line compare.
- `ID_W`, default 4: AXI ID width.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `i_araddr` in 32, `i_arlen` in 4, `i_arsize` in 3, `i_arvalid` in 1, `i_arready` out 1: icache read request.
- `i_rdata` out 32, `i_rlast` out 1, `i_rvalid` out 1, `i_rready` in 1: icache read data.
- `d_araddr`, `d_arlen`, `d_arsize`, `d_arvalid` in / `d_arready` out: dcache read request (same widths as the icache request).
- `d_rdata`, `d_rlast`, `d_rvalid` out / `d_rready` in: dcache read data.
- `d_awaddr` in 32, `d_awlen` in 4, `d_awsize` in 3, `d_awvalid` in 1, `d_awready` out 1: dcache write address.
- `d_wdata` in 32, `d_wstrb` in 4, `d_wlast` in 1, `d_wvalid` in 1, `d_wready` out 1: dcache write data.
- `d_bvalid` out 1, `d_bready` in 1: dcache write response.
- AXI master read address: `arid`[ID_W], `araddr`[32], `arlen`[4], `arsize`[3], `arburst`[2], `arvalid` out; `arready` in.
- AXI master read data: `rid`, `rdata`, `rresp`, `rlast`, `rvalid` in; `rready` out.
- AXI master write address: `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awvalid` out; `awready` in.
- AXI master write data: `wid`, `wdata`, `wstrb`, `wlast`, `wvalid` out; `wready` in.
- AXI master write response: `bid`, `bresp`, `bvalid` in; `bready` out.

## Operation
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: select a requester from `i_arvalid`/`d_arvalid`.
  - On grant: latch addr/len/size and the owner, pulse the granted upstream `*_arready` for one cycle, go to R_ADDR.
  - R_ADDR: `arvalid`=1 with the latched fields. On `arready` go to R_DATA.
  - R_DATA: on `rvalid & rready & rlast` return to R_IDLE.
- Arbitration: round-robin on a `last_grant` bit (reset to icache, so dcache wins the first tie). A lone requester is always granted.
- Read ID: `arid` = 0 for icache, 1 for dcache. `arburst` = `awburst` = 2'b01 (INCR).
- Read data routing: in R_DATA, `rdata`/`rlast`/`rvalid` go only to the owner and `rready` = owner's `*_rready`. The non-owner's `*_rvalid` = 0.
- A beat whose `rid` ≠ the latched id is not forwarded, `rready` = 0 for it, and `err_id` is flagged (sticky, visible to simulation only).
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: on `d_awvalid`, latch the aw fields, pulse `d_awready`, go to W_ADDR.
  - W_ADDR: `awvalid`=1. On `awready` go to W_DATA.
  - W_DATA: W channel is combinational pass-through (`wvalid`=`d_wvalid`, `d_wready`=`wready`, `wid`=1). On the `wlast` handshake go to W_RESP.
  - W_RESP: `d_bvalid`=`bvalid`, `bready`=`d_bready`. On the handshake go to W_IDLE.
- Hazard: while the write FSM ≠ W_IDLE, an icache request with `i_araddr[31:LINE_OFFSET]` == latched `awaddr[31:LINE_OFFSET]` is not eligible for grant. dcache reads are never blocked.
- The read and write FSMs run independently and concurrently.
- `rresp`/`bresp` are ignored.

## Timing
- Reset (asynchronous, `resetn`=0): both FSMs go to idle. All valid/ready outputs = 0; all latched address/id registers = 0. Release is synchronous to `clk`.
- A reset asserted mid-burst abandons the transaction with no flush. Upstream blocks are reset by the same `resetn`.
- Latency, upstream `*_arvalid` to AXI `arvalid`: 2 cycles (grant cycle, then the registered R_ADDR state). `awvalid` has the same latency.
- Read and write data beats are combinational: 0 added cycles.
- Each upstream `*_arready`/`d_awready` pulse is exactly 1 cycle. Upstream must hold valid until that pulse.
- If a grant and the hazard release occur in the same cycle, the hazard release counts: an icache request blocked only by the hazard may be granted in the cycle the write FSM is already in W_IDLE, never earlier.
- At most one read and one write are outstanding.

## Structure
- Shared package `axi_pkg` holds:
  - `BURST_INCR` = 2'b01.
  - `ID_ICACHE` = 0, `ID_DCACHE` = 1.
  - Read and write state enums.
- The write FSM stays inline.
- Sub-module `rr_arb2` is the natural split: a 2-input round-robin arbiter with a grant-enable input and one-hot grant output, also reused by the instruction-fetch path.

## Test plan
- dcache alone reads 0x0000_1040 with arlen 7 → `arid`=1, `araddr`=0x0000_1040, `arlen`=7, `arburst`=01. 8 beats reach `d_rdata`; `i_rvalid` stays 0.
- icache and dcache request in the same cycle, twice → first grant dcache, second icache (round-robin). Each receives only its own 8 beats.
- dcache write-back to 0x0000_2000 (8 beats, `wstrb` 4'hF) → `awid`=1. Data is forwarded beat-for-beat; `d_bvalid` follows `bvalid`.
- Write-back to 0x0000_2000 pending while icache requests 0x0000_2010 → `i_arready` stays 0 until W_IDLE, then icache is granted. An icache request to 0x0000_3000 during the same write is granted immediately.
- Slave returns `rid`=0 while dcache owns the read → beat not forwarded, `err_id`=1.
- `resetn` pulled low mid R_DATA → all outputs 0 asynchronously. The next request completes normally.
